fp_execute_stage4: RTL and testbench

Fourth floating-point pipeline stage. Normalizes the unnormalized add/subtract/itof sums from stage 3 via leading-zero count, left shift and exponent adjust. Aligns the 48-bit multiply product and extracts guard/round/sticky for it. Registers everything for the rounding/packing stage 5; one instruction per cycle, fixed 1-cycle latency, no stall.

---
 rtl/fp_execute_stage4.sv | 224 ++++++++++++++++++++++
 tb/tb_fp_execute_stage4.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_execute_stage4.sv
// Floating-point pipeline stage 4: normalizes add/sub/itof sums by leading-zero
// count and aligns multiply products, registering all results for stage 5.

package fp_execute_stage4_pkg;
    localparam int NUM_VECTOR_LANES = 16;
    localparam int INSTR_W          = 32;
    localparam int ALU_OP_W         = 6;
    localparam int THREAD_IDX_W     = 2;
    localparam int SUBCYCLE_W       = 4;
    // alu_op occupies the low ALU_OP_W bits of the decoded instruction word
    localparam logic [ALU_OP_W-1:0] OP_FTOI = 6'h1b;
endpackage

module fp_execute_stage4
    import fp_execute_stage4_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           fx3_instruction_valid,
    input  logic [INSTR_W-1:0]             fx3_instruction,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_mask_value,
    input  logic [THREAD_IDX_W-1:0]        fx3_thread_idx,
    input  logic [SUBCYCLE_W-1:0]          fx3_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_result_inf,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_result_nan,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_equal,
    input  logic [NUM_VECTOR_LANES*32-1:0] fx3_add_significand,
    input  logic [NUM_VECTOR_LANES*8-1:0]  fx3_add_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_logical_subtract,
    input  logic [NUM_VECTOR_LANES*64-1:0] fx3_significand_product,
    input  logic [NUM_VECTOR_LANES*8-1:0]  fx3_mul_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_mul_underflow,
    input  logic [NUM_VECTOR_LANES-1:0]    fx3_mul_sign,
    output logic                           fx4_instruction_valid,
    output logic [INSTR_W-1:0]             fx4_instruction,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mask_value,
    output logic [THREAD_IDX_W-1:0]        fx4_thread_idx,
    output logic [SUBCYCLE_W-1:0]          fx4_subcycle,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_result_inf,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_result_nan,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_equal,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_sign,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_underflow,
    output logic [NUM_VECTOR_LANES*6-1:0]  fx4_norm_shift,
    output logic [NUM_VECTOR_LANES*32-1:0] fx4_add_significand,
    output logic [NUM_VECTOR_LANES*8-1:0]  fx4_add_exponent,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_add_zero,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_add_underflow,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_add_overflow,
    output logic [NUM_VECTOR_LANES*23-1:0] fx4_mul_mantissa,
    output logic [NUM_VECTOR_LANES*8-1:0]  fx4_mul_exponent,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_guard,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_round,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_sticky,
    output logic [NUM_VECTOR_LANES-1:0]    fx4_mul_overflow
);
    localparam int NL = NUM_VECTOR_LANES;

    logic          is_ftoi;
    logic [NL-1:0] unused_prod_hi;
    logic          unused_inputs;

    assign is_ftoi       = (fx3_instruction[ALU_OP_W-1:0] == OP_FTOI);
    assign unused_inputs = ^{fx3_logical_subtract, unused_prod_hi};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fx4_instruction_valid <= 1'b0;
            fx4_instruction       <= '0;
            fx4_mask_value        <= '0;
            fx4_thread_idx        <= '0;
            fx4_subcycle          <= '0;
            fx4_result_inf        <= '0;
            fx4_result_nan        <= '0;
            fx4_equal             <= '0;
            fx4_add_result_sign   <= '0;
            fx4_mul_sign          <= '0;
            fx4_mul_underflow     <= '0;
        end else begin
            fx4_instruction_valid <= fx3_instruction_valid;
            fx4_instruction       <= fx3_instruction;
            fx4_mask_value        <= fx3_mask_value;
            fx4_thread_idx        <= fx3_thread_idx;
            fx4_subcycle          <= fx3_subcycle;
            fx4_result_inf        <= fx3_result_inf;
            fx4_result_nan        <= fx3_result_nan;
            fx4_equal             <= fx3_equal;
            fx4_add_result_sign   <= fx3_add_result_sign;
            fx4_mul_sign          <= fx3_mul_sign;
            fx4_mul_underflow     <= fx3_mul_underflow;
        end
    end

    for (genvar lane = 0; lane < NL; lane++) begin : g_lane
        logic [31:0]       sum;
        logic [7:0]        add_exp_in;
        logic [47:0]       prod;
        logic [7:0]        mul_exp_in;
        logic [5:0]        clz;
        logic signed [9:0] exp_adj;
        logic [8:0]        mul_exp_inc;

        logic [5:0]  norm_shift_d, norm_shift_q;
        logic [31:0] add_sig_d, add_sig_q;
        logic [7:0]  add_exp_d, add_exp_q;
        logic        add_zero_d, add_zero_q;
        logic        add_uf_d, add_uf_q;
        logic        add_of_d, add_of_q;
        logic [22:0] mul_mant_d, mul_mant_q;
        logic [7:0]  mul_exp_d, mul_exp_q;
        logic        guard_d, guard_q;
        logic        round_d, round_q;
        logic        sticky_d, sticky_q;
        logic        mul_of_d, mul_of_q;

        assign sum                  = fx3_add_significand[lane*32 +: 32];
        assign add_exp_in           = fx3_add_exponent[lane*8 +: 8];
        assign prod                 = fx3_significand_product[lane*64 +: 48];
        assign mul_exp_in           = fx3_mul_exponent[lane*8 +: 8];
        assign unused_prod_hi[lane] = ^fx3_significand_product[lane*64+48 +: 16];

        // Highest set bit wins because it is visited last.
        always_comb begin
            clz = 6'd32;
            for (int b = 0; b < 32; b++) begin
                if (sum[b]) clz = 6'(31 - b);
            end
        end

        // Hidden bit nominally sits at bit 23, so a fully normalized MSB at bit 31 adds 8.
        assign exp_adj     = $signed({2'b00, add_exp_in}) + 10'sd8 - $signed({4'b0000, clz});
        assign mul_exp_inc = {1'b0, mul_exp_in} + 9'd1;

        always_comb begin
            norm_shift_d = clz;
            add_sig_d    = sum << clz;
            add_exp_d    = exp_adj[7:0];
            add_zero_d   = 1'b0;
            add_uf_d     = 1'b0;
            add_of_d     = 1'b0;
            if (is_ftoi) begin
                norm_shift_d = 6'd0;
                add_sig_d    = sum;
                add_exp_d    = add_exp_in;
            end else if (sum == 32'd0) begin
                add_zero_d = 1'b1;
                add_exp_d  = 8'd0;
            end else if (exp_adj <= 10'sd0) begin
                add_uf_d  = 1'b1;
                add_exp_d = 8'd0;
            end else if (exp_adj >= 10'sd255) begin
                add_of_d  = 1'b1;
                add_exp_d = 8'hff;
            end
        end

        always_comb begin
            mul_mant_d = prod[45:23];
            guard_d    = prod[22];
            round_d    = prod[21];
            sticky_d   = |prod[20:0];
            mul_exp_d  = mul_exp_in;
            mul_of_d   = 1'b0;
            if (prod[47]) begin
                mul_mant_d = prod[46:24];
                guard_d    = prod[23];
                round_d    = prod[22];
                sticky_d   = |prod[21:0];
                if (mul_exp_inc >= 9'd255) begin
                    mul_of_d  = 1'b1;
                    mul_exp_d = 8'hff;
                end else begin
                    mul_exp_d = mul_exp_inc[7:0];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                norm_shift_q <= '0;
                add_sig_q    <= '0;
                add_exp_q    <= '0;
                add_zero_q   <= 1'b0;
                add_uf_q     <= 1'b0;
                add_of_q     <= 1'b0;
                mul_mant_q   <= '0;
                mul_exp_q    <= '0;
                guard_q      <= 1'b0;
                round_q      <= 1'b0;
                sticky_q     <= 1'b0;
                mul_of_q     <= 1'b0;
            end else begin
                norm_shift_q <= norm_shift_d;
                add_sig_q    <= add_sig_d;
                add_exp_q    <= add_exp_d;
                add_zero_q   <= add_zero_d;
                add_uf_q     <= add_uf_d;
                add_of_q     <= add_of_d;
                mul_mant_q   <= mul_mant_d;
                mul_exp_q    <= mul_exp_d;
                guard_q      <= guard_d;
                round_q      <= round_d;
                sticky_q     <= sticky_d;
                mul_of_q     <= mul_of_d;
            end
        end

        assign fx4_norm_shift[lane*6 +: 6]       = norm_shift_q;
        assign fx4_add_significand[lane*32 +: 32] = add_sig_q;
        assign fx4_add_exponent[lane*8 +: 8]     = add_exp_q;
        assign fx4_add_zero[lane]                = add_zero_q;
        assign fx4_add_underflow[lane]           = add_uf_q;
        assign fx4_add_overflow[lane]            = add_of_q;
        assign fx4_mul_mantissa[lane*23 +: 23]   = mul_mant_q;
        assign fx4_mul_exponent[lane*8 +: 8]     = mul_exp_q;
        assign fx4_mul_guard[lane]               = guard_q;
        assign fx4_mul_round[lane]               = round_q;
        assign fx4_mul_sticky[lane]              = sticky_q;
        assign fx4_mul_overflow[lane]            = mul_of_q;
    end

endmodule

// File: tb/tb_fp_execute_stage4.sv
// Scoreboard bench for fp_execute_stage4: directed normalization/alignment
// cases, a random stream and an asynchronous reset pulse mid-stream.

module tb_fp_execute_stage4;
    import fp_execute_stage4_pkg::*;

    localparam int NL = NUM_VECTOR_LANES;

    typedef struct packed {
        logic                     valid;
        logic [INSTR_W-1:0]       instr;
        logic [NL-1:0]            mask;
        logic [THREAD_IDX_W-1:0]  thread;
        logic [SUBCYCLE_W-1:0]    subcycle;
        logic [NL-1:0]            inf;
        logic [NL-1:0]            nan;
        logic [NL-1:0]            equal;
        logic [NL*32-1:0]         sum;
        logic [NL*8-1:0]          addExp;
        logic [NL-1:0]            addSign;
        logic [NL-1:0]            logicalSub;
        logic [NL*64-1:0]         prod;
        logic [NL*8-1:0]          mulExp;
        logic [NL-1:0]            mulUnder;
        logic [NL-1:0]            mulSign;
    } stim_t;

    typedef struct packed {
        logic                     valid;
        logic [INSTR_W-1:0]       instr;
        logic [NL-1:0]            mask;
        logic [THREAD_IDX_W-1:0]  thread;
        logic [SUBCYCLE_W-1:0]    subcycle;
        logic [NL-1:0]            inf;
        logic [NL-1:0]            nan;
        logic [NL-1:0]            equal;
        logic [NL-1:0]            addSign;
        logic [NL-1:0]            mulSign;
        logic [NL-1:0]            mulUnder;
        logic [NL*6-1:0]          normShift;
        logic [NL*32-1:0]         addSig;
        logic [NL*8-1:0]          addExp;
        logic [NL-1:0]            addZero;
        logic [NL-1:0]            addUf;
        logic [NL-1:0]            addOf;
        logic [NL*23-1:0]         mulMant;
        logic [NL*8-1:0]          mulExp;
        logic [NL-1:0]            guard;
        logic [NL-1:0]            round;
        logic [NL-1:0]            sticky;
        logic [NL-1:0]            mulOf;
    } expect_t;

    logic clk;
    logic reset_n;

    logic                    fx3_instruction_valid;
    logic [INSTR_W-1:0]      fx3_instruction;
    logic [NL-1:0]           fx3_mask_value;
    logic [THREAD_IDX_W-1:0] fx3_thread_idx;
    logic [SUBCYCLE_W-1:0]   fx3_subcycle;
    logic [NL-1:0]           fx3_result_inf, fx3_result_nan, fx3_equal;
    logic [NL*32-1:0]        fx3_add_significand;
    logic [NL*8-1:0]         fx3_add_exponent;
    logic [NL-1:0]           fx3_add_result_sign, fx3_logical_subtract;
    logic [NL*64-1:0]        fx3_significand_product;
    logic [NL*8-1:0]         fx3_mul_exponent;
    logic [NL-1:0]           fx3_mul_underflow, fx3_mul_sign;

    logic                    fx4_instruction_valid;
    logic [INSTR_W-1:0]      fx4_instruction;
    logic [NL-1:0]           fx4_mask_value;
    logic [THREAD_IDX_W-1:0] fx4_thread_idx;
    logic [SUBCYCLE_W-1:0]   fx4_subcycle;
    logic [NL-1:0]           fx4_result_inf, fx4_result_nan, fx4_equal;
    logic [NL-1:0]           fx4_add_result_sign, fx4_mul_sign, fx4_mul_underflow;
    logic [NL*6-1:0]         fx4_norm_shift;
    logic [NL*32-1:0]        fx4_add_significand;
    logic [NL*8-1:0]         fx4_add_exponent;
    logic [NL-1:0]           fx4_add_zero, fx4_add_underflow, fx4_add_overflow;
    logic [NL*23-1:0]        fx4_mul_mantissa;
    logic [NL*8-1:0]         fx4_mul_exponent;
    logic [NL-1:0]           fx4_mul_guard, fx4_mul_round, fx4_mul_sticky, fx4_mul_overflow;

    int testsRun    = 0;
    int testsFailed = 0;
    expect_t scoreboard[$];

    fp_execute_stage4 dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .fx3_instruction_valid   (fx3_instruction_valid),
        .fx3_instruction         (fx3_instruction),
        .fx3_mask_value          (fx3_mask_value),
        .fx3_thread_idx          (fx3_thread_idx),
        .fx3_subcycle            (fx3_subcycle),
        .fx3_result_inf          (fx3_result_inf),
        .fx3_result_nan          (fx3_result_nan),
        .fx3_equal               (fx3_equal),
        .fx3_add_significand     (fx3_add_significand),
        .fx3_add_exponent        (fx3_add_exponent),
        .fx3_add_result_sign     (fx3_add_result_sign),
        .fx3_logical_subtract    (fx3_logical_subtract),
        .fx3_significand_product (fx3_significand_product),
        .fx3_mul_exponent        (fx3_mul_exponent),
        .fx3_mul_underflow       (fx3_mul_underflow),
        .fx3_mul_sign            (fx3_mul_sign),
        .fx4_instruction_valid   (fx4_instruction_valid),
        .fx4_instruction         (fx4_instruction),
        .fx4_mask_value          (fx4_mask_value),
        .fx4_thread_idx          (fx4_thread_idx),
        .fx4_subcycle            (fx4_subcycle),
        .fx4_result_inf          (fx4_result_inf),
        .fx4_result_nan          (fx4_result_nan),
        .fx4_equal               (fx4_equal),
        .fx4_add_result_sign     (fx4_add_result_sign),
        .fx4_mul_sign            (fx4_mul_sign),
        .fx4_mul_underflow       (fx4_mul_underflow),
        .fx4_norm_shift          (fx4_norm_shift),
        .fx4_add_significand     (fx4_add_significand),
        .fx4_add_exponent        (fx4_add_exponent),
        .fx4_add_zero            (fx4_add_zero),
        .fx4_add_underflow       (fx4_add_underflow),
        .fx4_add_overflow        (fx4_add_overflow),
        .fx4_mul_mantissa        (fx4_mul_mantissa),
        .fx4_mul_exponent        (fx4_mul_exponent),
        .fx4_mul_guard           (fx4_mul_guard),
        .fx4_mul_round           (fx4_mul_round),
        .fx4_mul_sticky          (fx4_mul_sticky),
        .fx4_mul_overflow        (fx4_mul_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkResult(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int countLeading(input logic [31:0] v);
        int n = 0;
        while (n < 32 && !v[31]) begin
            v = v << 1;
            n++;
        end
        return n;
    endfunction

    function automatic expect_t model(input stim_t s);
        expect_t ex;
        logic    ftoi;
        ex          = '0;
        ftoi        = (s.instr[ALU_OP_W-1:0] == OP_FTOI);
        ex.valid    = s.valid;
        ex.instr    = s.instr;
        ex.mask     = s.mask;
        ex.thread   = s.thread;
        ex.subcycle = s.subcycle;
        ex.inf      = s.inf;
        ex.nan      = s.nan;
        ex.equal    = s.equal;
        ex.addSign  = s.addSign;
        ex.mulSign  = s.mulSign;
        ex.mulUnder = s.mulUnder;
        for (int l = 0; l < NL; l++) begin
            logic [31:0] sum;
            logic [7:0]  ae;
            logic [7:0]  me;
            logic [47:0] p;
            int          n;
            int          e;
            sum = s.sum[l*32 +: 32];
            ae  = s.addExp[l*8 +: 8];
            me  = s.mulExp[l*8 +: 8];
            p   = s.prod[l*64 +: 48];
            if (ftoi) begin
                ex.addSig[l*32 +: 32] = sum;
                ex.addExp[l*8 +: 8]   = ae;
            end else begin
                n = countLeading(sum);
                e = int'(ae) + 8 - n;
                ex.normShift[l*6 +: 6] = 6'(n);
                ex.addSig[l*32 +: 32]  = sum << n;
                if (sum == 32'd0) begin
                    ex.addZero[l] = 1'b1;
                end else if (e <= 0) begin
                    ex.addUf[l] = 1'b1;
                end else if (e >= 255) begin
                    ex.addOf[l]         = 1'b1;
                    ex.addExp[l*8 +: 8] = 8'hff;
                end else begin
                    ex.addExp[l*8 +: 8] = 8'(e);
                end
            end
            if (p[47]) begin
                ex.mulMant[l*23 +: 23] = p[46:24];
                ex.guard[l]            = p[23];
                ex.round[l]            = p[22];
                ex.sticky[l]           = (p[21:0] != 22'd0);
                if (int'(me) + 1 >= 255) begin
                    ex.mulOf[l]         = 1'b1;
                    ex.mulExp[l*8 +: 8] = 8'hff;
                end else begin
                    ex.mulExp[l*8 +: 8] = me + 8'd1;
                end
            end else begin
                ex.mulMant[l*23 +: 23] = p[45:23];
                ex.guard[l]            = p[22];
                ex.round[l]            = p[21];
                ex.sticky[l]           = (p[20:0] != 21'd0);
                ex.mulExp[l*8 +: 8]    = me;
            end
        end
        return ex;
    endfunction

    function automatic logic [7:0] pickExp();
        logic [7:0] edges [4] = '{8'd0, 8'd1, 8'd254, 8'd255};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic stim_t randomStim(input logic valid, input logic ftoi);
        stim_t       s;
        logic [31:0] w;
        logic [31:0] pa;
        logic [31:0] pb;
        logic [47:0] p;
        w           = $urandom;
        w[5:0]      = ftoi ? OP_FTOI : 6'($urandom_range(0, 26));
        s           = '0;
        s.valid     = valid;
        s.instr     = w;
        s.mask      = 16'($urandom);
        s.thread    = 2'($urandom);
        s.subcycle  = 4'($urandom);
        s.inf       = 16'($urandom);
        s.nan       = 16'($urandom);
        s.equal     = 16'($urandom);
        s.addSign   = 16'($urandom);
        s.logicalSub = 16'($urandom);
        s.mulUnder  = 16'($urandom);
        s.mulSign   = 16'($urandom);
        for (int l = 0; l < NL; l++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0:       s.sum[l*32 +: 32] = 32'd0;
                1:       s.sum[l*32 +: 32] = 32'h1 << $urandom_range(0, 31);
                default: s.sum[l*32 +: 32] = w >> $urandom_range(0, 31);
            endcase
            s.addExp[l*8 +: 8] = pickExp();
            s.mulExp[l*8 +: 8] = pickExp();
            pa = $urandom;
            pb = $urandom;
            p  = {pa[15:0], pb};
            if ($urandom_range(0, 1) == 0) p[47] = 1'b0;
            s.prod[l*64 +: 64] = {16'h0, p};
        end
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        fx3_instruction_valid   = s.valid;
        fx3_instruction         = s.instr;
        fx3_mask_value          = s.mask;
        fx3_thread_idx          = s.thread;
        fx3_subcycle            = s.subcycle;
        fx3_result_inf          = s.inf;
        fx3_result_nan          = s.nan;
        fx3_equal               = s.equal;
        fx3_add_significand     = s.sum;
        fx3_add_exponent        = s.addExp;
        fx3_add_result_sign     = s.addSign;
        fx3_logical_subtract    = s.logicalSub;
        fx3_significand_product = s.prod;
        fx3_mul_exponent        = s.mulExp;
        fx3_mul_underflow       = s.mulUnder;
        fx3_mul_sign            = s.mulSign;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
        scoreboard.push_back(model(s));
    endtask

    // Called #1 after the capturing posedge; pops the entry pushed for that edge.
    task automatic checkOutput();
        expect_t ex;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkResult("scoreboard_empty", 1'b1, 1'b0);
            return;
        end
        ex = scoreboard.pop_front();
        checkResult("valid",       fx4_instruction_valid, ex.valid);
        checkResult("instruction", fx4_instruction,       ex.instr);
        checkResult("mask",        fx4_mask_value,        ex.mask);
        checkResult("thread",      fx4_thread_idx,        ex.thread);
        checkResult("subcycle",    fx4_subcycle,          ex.subcycle);
        checkResult("inf",         fx4_result_inf,        ex.inf);
        checkResult("nan",         fx4_result_nan,        ex.nan);
        checkResult("equal",       fx4_equal,             ex.equal);
        checkResult("add_sign",    fx4_add_result_sign,   ex.addSign);
        checkResult("mul_sign",    fx4_mul_sign,          ex.mulSign);
        checkResult("mul_under",   fx4_mul_underflow,     ex.mulUnder);
        checkResult("norm_shift",  fx4_norm_shift,        ex.normShift);
        checkResult("add_sig",     fx4_add_significand,   ex.addSig);
        checkResult("add_exp",     fx4_add_exponent,      ex.addExp);
        checkResult("add_zero",    fx4_add_zero,          ex.addZero);
        checkResult("add_uf",      fx4_add_underflow,     ex.addUf);
        checkResult("add_of",      fx4_add_overflow,      ex.addOf);
        checkResult("mul_mant",    fx4_mul_mantissa,      ex.mulMant);
        checkResult("mul_exp",     fx4_mul_exponent,      ex.mulExp);
        checkResult("guard",       fx4_mul_guard,         ex.guard);
        checkResult("round",       fx4_mul_round,         ex.round);
        checkResult("sticky",      fx4_mul_sticky,        ex.sticky);
        checkResult("mul_of",      fx4_mul_overflow,      ex.mulOf);
    endtask

    task automatic checkZeroed(input string tag);
        checkResult({tag, "_valid"},    fx4_instruction_valid, 1'b0);
        checkResult({tag, "_instr"},    fx4_instruction,       '0);
        checkResult({tag, "_shift"},    fx4_norm_shift,        '0);
        checkResult({tag, "_add_sig"},  fx4_add_significand,   '0);
        checkResult({tag, "_add_exp"},  fx4_add_exponent,      '0);
        checkResult({tag, "_mul_mant"}, fx4_mul_mantissa,      '0);
        checkResult({tag, "_mul_exp"},  fx4_mul_exponent,      '0);
        checkResult({tag, "_flags"},    {fx4_result_inf, fx4_mul_sticky, fx4_add_zero}, '0);
    endtask

    initial begin
        stim_t s;
        reset_n = 1'b0;
        driveInputs('0);
        repeat (2) @(posedge clk);
        #1;
        checkZeroed("reset");
        @(negedge clk);
        reset_n = 1'b1;

        s = randomStim(1'b1, 1'b0);
        s.sum[0*32 +: 32]  = 32'h0080_0000; s.addExp[0*8 +: 8] = 8'd127;
        s.sum[1*32 +: 32]  = 32'h0100_0000; s.addExp[1*8 +: 8] = 8'd127;
        s.sum[2*32 +: 32]  = 32'h0100_0000; s.addExp[2*8 +: 8] = 8'd254;
        s.sum[3*32 +: 32]  = 32'h0000_0000; s.addExp[3*8 +: 8] = 8'd100;
        s.sum[4*32 +: 32]  = 32'h0000_0001; s.addExp[4*8 +: 8] = 8'd10;
        s.prod[0*64 +: 64] = 64'h0000_C000_0080_0001; s.mulExp[0*8 +: 8] = 8'd130;
        s.prod[1*64 +: 64] = 64'h0000_4000_0000_0000; s.mulExp[1*8 +: 8] = 8'd254;
        applyStimulus(s);
        checkOutput();
        checkResult("d0_shift",    fx4_norm_shift[0*6 +: 6],       6'd8);
        checkResult("d0_sig",      fx4_add_significand[0 +: 32],   32'h8000_0000);
        checkResult("d0_exp",      fx4_add_exponent[0 +: 8],       8'd127);
        checkResult("d0_flags",    {fx4_add_zero[0], fx4_add_underflow[0], fx4_add_overflow[0]}, 3'b000);
        checkResult("d1_shift",    fx4_norm_shift[1*6 +: 6],       6'd7);
        checkResult("d1_exp",      fx4_add_exponent[1*8 +: 8],     8'd128);
        checkResult("d2_of",       fx4_add_overflow[2],            1'b1);
        checkResult("d2_exp",      fx4_add_exponent[2*8 +: 8],     8'hff);
        checkResult("d3_shift",    fx4_norm_shift[3*6 +: 6],       6'd32);
        checkResult("d3_sig",      fx4_add_significand[3*32 +: 32], 32'd0);
        checkResult("d3_zero_exp", {fx4_add_zero[3], fx4_add_exponent[3*8 +: 8]}, 9'h100);
        checkResult("d4_uf_exp",   {fx4_add_underflow[4], fx4_add_exponent[4*8 +: 8]}, 9'h100);
        checkResult("m0_mant",     fx4_mul_mantissa[0 +: 23],      23'h40_0000);
        checkResult("m0_exp",      fx4_mul_exponent[0 +: 8],       8'd131);
        checkResult("m0_grs",      {fx4_mul_guard[0], fx4_mul_round[0], fx4_mul_sticky[0]}, 3'b101);
        checkResult("m1_mant",     fx4_mul_mantissa[1*23 +: 23],   23'd0);
        checkResult("m1_exp",      fx4_mul_exponent[1*8 +: 8],     8'd254);
        checkResult("m1_grs_of",   {fx4_mul_guard[1], fx4_mul_round[1], fx4_mul_sticky[1], fx4_mul_overflow[1]}, 4'b0000);

        s = randomStim(1'b1, 1'b1);
        s.sum[0*32 +: 32] = 32'h0000_002A;
        applyStimulus(s);
        checkOutput();
        checkResult("ftoi_sig",   fx4_add_significand[0 +: 32], 32'h0000_002A);
        checkResult("ftoi_shift", fx4_norm_shift[0 +: 6],       6'd0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(randomStim(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0)));
            checkOutput();
        end

        applyStimulus(randomStim(1'b1, 1'b0));
        checkOutput();
        #1;
        reset_n = 1'b0;
        #1;
        checkZeroed("midreset");
        #1;
        reset_n = 1'b1;
        applyStimulus(randomStim(1'b0, 1'b0));
        checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(randomStim(1'b1, 1'b0));
            checkOutput();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
